// File: rtl/datapath_pkg.sv
// Shared types and ALU opcodes for the single-bus datapath.
// The control unit imports the same opcode encodings.
package datapath_pkg;

  typedef logic [31:0] word_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_SHR  = 5'b00100;
  localparam logic [4:0] ALU_SHRA = 5'b00101;
  localparam logic [4:0] ALU_SHL  = 5'b00110;
  localparam logic [4:0] ALU_ROL  = 5'b00111;
  localparam logic [4:0] ALU_ROR  = 5'b01000;
  localparam logic [4:0] ALU_NEG  = 5'b01001;
  localparam logic [4:0] ALU_NOT  = 5'b01010;

  // Register slots in the datapath register array.
  localparam int RI_PC  = 0;
  localparam int RI_MDR = 1;
  localparam int RI_MAR = 2;
  localparam int RI_IR  = 3;
  localparam int RI_Y   = 4;
  localparam int RI_ZLO = 5;
  localparam int RI_R2  = 6;
  localparam int RI_R4  = 7;
  localparam int RI_R5  = 8;
  localparam int NREG   = 9;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus.
// IncPC overrides CONTROL with B + 1.
module alu
  import datapath_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  CONTROL,
  input  logic        IncPC,
  output logic [31:0] Result
);

  logic [4:0]  sh;
  logic [63:0] rol_w;
  logic [63:0] ror_w;

  assign sh    = B[4:0];
  assign rol_w = {A, A} << sh;
  assign ror_w = {A, A} >> sh;

  always_comb begin
    Result = '0;
    if (IncPC) begin
      Result = B + 32'd1;
    end else begin
      case (CONTROL)
        ALU_ADD:  Result = A + B;
        ALU_SUB:  Result = A - B;
        ALU_AND:  Result = A & B;
        ALU_OR:   Result = A | B;
        ALU_SHR:  Result = A >> sh;
        ALU_SHRA: Result = $signed(A) >>> sh;
        ALU_SHL:  Result = A << sh;
        ALU_ROL:  Result = rol_w[63:32];
        ALU_ROR:  Result = ror_w[31:0];
        ALU_NEG:  Result = '0 - B;
        ALU_NOT:  Result = ~B;
        default:  Result = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: priority bus mux,
// enabled register array and one ALU.
module datapath
  import datapath_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] MData_In,
  input  logic [4:0]  CONTROL,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        PC_Out,
  input  logic        MDR_Out,
  input  logic        ZLO_Out,
  input  logic        R2_Out,
  input  logic        R4_Out,
  input  logic        PC_In,
  input  logic        MDR_In,
  input  logic        MAR_In,
  input  logic        IR_In,
  input  logic        Y_In,
  input  logic        ZLO_In,
  input  logic        R2_In,
  input  logic        R4_In,
  input  logic        R5_In,
  output logic [31:0] BusMux_Out,
  output logic [31:0] R5_Q
);

  logic [NREG-1:0][31:0] regs_q;
  logic [NREG-1:0][31:0] regs_d;
  logic [NREG-1:0]       ld;
  word_t                 bus;
  word_t                 alu_res;

  always_comb begin
    bus = '0;
    if (PC_Out)       bus = regs_q[RI_PC];
    else if (MDR_Out) bus = regs_q[RI_MDR];
    else if (ZLO_Out) bus = regs_q[RI_ZLO];
    else if (R2_Out)  bus = regs_q[RI_R2];
    else if (R4_Out)  bus = regs_q[RI_R4];
  end

  alu u_alu (
    .A       (regs_q[RI_Y]),
    .B       (bus),
    .CONTROL (CONTROL),
    .IncPC   (IncPC),
    .Result  (alu_res)
  );

  always_comb begin
    ld         = '0;
    ld[RI_PC]  = PC_In;
    ld[RI_MDR] = MDR_In;
    ld[RI_MAR] = MAR_In;
    ld[RI_IR]  = IR_In;
    ld[RI_Y]   = Y_In;
    ld[RI_ZLO] = ZLO_In;
    ld[RI_R2]  = R2_In;
    ld[RI_R4]  = R4_In;
    ld[RI_R5]  = R5_In;
  end

  // Everything loads from the bus except MDR (memory mux) and ZLO (ALU).
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = bus;
    regs_d[RI_MDR] = Read ? MData_In : bus;
    regs_d[RI_ZLO] = alu_res;
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (ld[i]) regs_q[i] <= regs_d[i];
    end
  end

  assign BusMux_Out = bus;
  assign R5_Q       = regs_q[RI_R5];

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the datapath.
// Bench acts as the control unit, one strobe set per clock.
module tb_datapath;
  import datapath_pkg::*;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] MData_In;
  logic [4:0]  CONTROL;
  logic        IncPC, Read;
  logic        PC_Out, MDR_Out, ZLO_Out, R2_Out, R4_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In;
  logic        ZLO_In, R2_In, R4_In, R5_In;
  logic [31:0] BusMux_Out, R5_Q;

  int n_vec = 0;
  int n_bad = 0;

  datapath dut (
    .Clock(Clock), .Clear(Clear), .MData_In(MData_In),
    .CONTROL(CONTROL), .IncPC(IncPC), .Read(Read),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out),
    .R2_Out(R2_Out), .R4_Out(R4_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In),
    .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In),
    .R2_In(R2_In), .R4_In(R4_In), .R5_In(R5_In),
    .BusMux_Out(BusMux_Out), .R5_Q(R5_Q)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Clear = 0; Read = 0; IncPC = 0; CONTROL = ALU_ADD;
    PC_Out = 0; MDR_Out = 0; ZLO_Out = 0; R2_Out = 0; R4_Out = 0;
    PC_In = 0; MDR_In = 0; MAR_In = 0; IR_In = 0; Y_In = 0;
    ZLO_In = 0; R2_In = 0; R4_In = 0; R5_In = 0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic bus_chk(input string tag, input logic [31:0] exp);
    #1;
    chk(tag, BusMux_Out, exp);
    idle();
  endtask

  task automatic mem_ld(input logic [31:0] v);
    MData_In = v; Read = 1; MDR_In = 1; step();
  endtask

  // Y = 0xFFFFFFF0, MDR already holds B; runs op and checks ZLO.
  task automatic alu_op(input string tag, input logic [4:0] op,
                        input logic [31:0] exp);
    MDR_Out = 1; CONTROL = op; ZLO_In = 1; step();
    ZLO_Out = 1; bus_chk(tag, exp);
  endtask

  initial begin
    MData_In = '0;
    idle();
    Clear = 1; step();
    PC_Out = 1; bus_chk("rst_init_pc", 32'h0);
    chk("rst_init_r5", R5_Q, 32'h0);

    mem_ld(32'd5);
    MDR_Out = 1; ZLO_In = 1; step();
    ZLO_Out = 1; PC_In = 1; step();
    PC_Out = 1; bus_chk("pc_eq5", 32'd5);
    // Clear wins over a simultaneous load
    Clear = 1; ZLO_Out = 1; PC_In = 1; step();
    PC_Out = 1; bus_chk("rst_pc", 32'h0);
    ZLO_Out = 1; bus_chk("rst_zlo", 32'h0);
    MDR_Out = 1; bus_chk("rst_mdr", 32'h0);
    chk("rst_r5", R5_Q, 32'h0);

    mem_ld(32'hE000_0000);
    MDR_Out = 1; bus_chk("mdr_mem", 32'hE000_0000);
    MDR_Out = 1; R2_In = 1; step();
    R2_Out = 1; bus_chk("r2_ld", 32'hE000_0000);

    PC_Out = 1; MAR_In = 1; IncPC = 1; ZLO_In = 1; step();
    ZLO_Out = 1; PC_In = 1; step();
    PC_Out = 1; bus_chk("fetch_pc", 32'h1);

    mem_ld(32'd2);
    MDR_Out = 1; R4_In = 1; step();
    R2_Out = 1; Y_In = 1; step();
    R4_Out = 1; CONTROL = ALU_ROL; ZLO_In = 1; step();
    ZLO_Out = 1; bus_chk("rol_zlo", 32'h8000_0003);
    ZLO_Out = 1; R5_In = 1; step();
    chk("rol_r5", R5_Q, 32'h8000_0003);

    mem_ld(32'hFFFF_FFF0);
    MDR_Out = 1; Y_In = 1; step();
    mem_ld(32'd4);
    alu_op("shra", ALU_SHRA, 32'hFFFF_FFFF);
    alu_op("shr",  ALU_SHR,  32'h0FFF_FFFF);
    alu_op("add",  ALU_ADD,  32'hFFFF_FFF4);
    alu_op("sub",  ALU_SUB,  32'hFFFF_FFEC);
    alu_op("and",  ALU_AND,  32'h0000_0000);
    alu_op("or",   ALU_OR,   32'hFFFF_FFF4);
    alu_op("shl",  ALU_SHL,  32'hFFFF_FF00);
    alu_op("ror",  ALU_ROR,  32'h0FFF_FFFF);
    alu_op("neg",  ALU_NEG,  32'hFFFF_FFFC);
    alu_op("not",  ALU_NOT,  32'hFFFF_FFFB);
    alu_op("bad_op", 5'b01011, 32'h0000_0000);
    MDR_Out = 1; CONTROL = ALU_SUB; IncPC = 1; ZLO_In = 1; step();
    ZLO_Out = 1; bus_chk("incpc_ovr", 32'h5);

    mem_ld(32'd32);
    alu_op("shl32", ALU_SHL, 32'hFFFF_FFF0);
    alu_op("shra32", ALU_SHRA, 32'hFFFF_FFF0);
    alu_op("rol32", ALU_ROL, 32'hFFFF_FFF0);

    R4_Out = 1; MDR_In = 1; step();
    MDR_Out = 1; bus_chk("mdr_bus", 32'd2);
    bus_chk("idle_bus", 32'h0);
    PC_Out = 1; R4_Out = 1; bus_chk("prio_pc_r4", 32'h1);
    MDR_Out = 1; ZLO_Out = 1; R2_Out = 1;
    bus_chk("prio_mdr", 32'd2);
    R2_Out = 1; R4_Out = 1; bus_chk("prio_r2", 32'hE000_0000);
    R2_Out = 1; R2_In = 1; step();
    R2_Out = 1; bus_chk("self_ld", 32'hE000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit CPU datapath for the Phase 1 processor: a shared bus, the PC, IR, MAR, MDR, Y and ZLO registers, general registers R2/R4/R5, and a combinational ALU. The control unit, or a bench acting as one, drives one-hot register-out and register-in strobes each clock. The block moves operands over the bus, fetches memory data through the MDR, increments the PC, and executes one ALU operation per Y/ZLO sequence.

## Interface
Parameters: none.

Ports, as name, direction, width, meaning:
- Clock — in, 1 — the single clock; all registers update on its rising edge.
- Clear — in, 1 — synchronous, active-high reset.
- MData_In — in, 32 — memory read data into the MDR.
- CONTROL — in, 5 — ALU operation select.
- IncPC — in, 1 — forces the ALU to compute bus + 1.
- Read — in, 1 — MDR input select: 1 selects MData_In, 0 selects the bus.
- PC_Out, MDR_Out, ZLO_Out, R2_Out, R4_Out — in, 1 each — bus-drive strobes.
- PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R2_In, R4_In, R5_In — in, 1 each — register load enables.
- BusMux_Out — out, 32 — current bus value.
- R5_Q — out, 32 — R5 contents, used for observation.

## Operation
- **Bus.** BusMux_Out is combinational.
  - It carries the value of the asserted *_Out register.
  - If several are asserted, priority is PC > MDR > ZLO > R2 > R4.
  - If none is asserted, the bus is 0.
- **Register load.** Each register loads on a rising edge when its *_In is high. Loads read the bus, with the MDR exception below.
- **MDR load.** MDR loads Read ? MData_In : bus.
- **Registers with no bus driver.** MAR, IR, Y and R5 only load; they never drive the bus.
- **ALU.** Operand A = Y, operand B = bus. The result is combinational and is latched into ZLO when ZLO_In is high.
- **IncPC.** When IncPC=1, result = B + 1 and CONTROL is ignored.
- **CONTROL codes:**
  - 00000 ADD A+B
  - 00001 SUB A−B
  - 00010 AND
  - 00011 OR
  - 00100 SHR: logical right, A by B[4:0]
  - 00101 SHRA: arithmetic right
  - 00110 SHL
  - 00111 ROL: rotate A left by B[4:0]
  - 01000 ROR
  - 01001 NEG: −B
  - 01010 NOT: ~B
  - all other codes: result 0.
- **Width rules.** Arithmetic is modulo 2^32 with carries discarded. Shift and rotate amounts use B[4:0] only, so B=32 means shift by 0.

## Timing
- **Reset.** A rising edge with Clear=1 zeroes PC, IR, MAR, MDR, Y, ZLO, R2, R4 and R5.
  - Clear has priority over every *_In in the same cycle.
  - After reset, BusMux_Out is 0 for any Out selection, and R5_Q is 0.
- **Register-to-register transfer.** Out and In are asserted in the same cycle and the destination updates at the next rising edge, giving 1-cycle latency.
- **Memory load.** Read + MDR_In captures MData_In at the edge.
- **ALU op.** The standard sequence is three cycles:
  - cycle 1: Rx_Out + Y_In
  - cycle 2: Ry_Out + CONTROL + ZLO_In
  - cycle 3: ZLO_Out + Rz_In.
- **Fetch.** Cycle 1: PC_Out + MAR_In + IncPC + ZLO_In loads MAR=PC and ZLO=PC+1. Cycle 2: ZLO_Out + PC_In.
- **Same register out and in.** When one register is both driven out and loaded in the same cycle, the old value is used, so a self-load is a no-op.
- **Strobes between edges.** Strobes may change mid-cycle; only values at the rising edge matter.
- **No handshakes.** There are no handshakes and no internal state machine.

## Structure
- **Shared package.**
  - The CONTROL opcode localparams (ALU_ADD … ALU_NOT), shared with the future control unit.
  - A 32-bit word typedef.
- **Sub-module.** `alu`: inputs A, B, CONTROL and IncPC; output a 32-bit result; purely combinational.
- **Remaining logic.** The bus mux and register file stay in `datapath`, as one generic enabled-register pattern instantiated per register.

## Test plan
- **Reset.** Load PC=5 via ZLO, then pulse Clear for one edge. With PC_Out asserted, BusMux_Out=0. R5_Q=0.
- **Memory load.**
  - MData_In=0xE0000000, Read=1, MDR_In=1 for one edge; then MDR_Out → BusMux_Out=0xE0000000.
  - MDR_Out + R2_In for one edge; then R2_Out → bus 0xE0000000.
- **Fetch increment.** From PC=0: PC_Out+MAR_In+IncPC+ZLO_In, then ZLO_Out+PC_In. Result: PC_Out → bus 0x00000001.
- **ROL.**
  - Setup: R2=0xE0000000, R4=2, then R2_Out+Y_In.
  - R4_Out + CONTROL=00111 + ZLO_In → ZLO=0x80000003.
  - ZLO_Out + R5_In → R5_Q=0x80000003.
- **Arithmetic and shifts.** Y=0xFFFFFFF0, bus=4:
  - SHRA → 0xFFFFFFFF
  - SHR → 0x0FFFFFFF
  - ADD → 0xFFFFFFF4
  - SUB → 0xFFFFFFEC
  - Shift by bus=32 → 0xFFFFFFF0.
- **Bus-path MDR and idle bus.**
  - Read=0, R4_Out (R4=2) + MDR_In → MDR=2.
  - With no Out strobe asserted, BusMux_Out=0.
  - With PC_Out and R4_Out asserted together, the bus carries PC.
